// File: rtl/kpg_prefix_adder_pipe.sv
// rtl/kpg_prefix_adder_pipe.sv - pipelined Kogge-Stone (KPG) adder/subtractor with valid/ready handshake
module kpg_prefix_adder_pipe #(
  parameter int WIDTH = 64,
  parameter int LPS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int L = $clog2(WIDTH);
  localparam int S = (L + LPS - 1) / LPS;
  localparam logic [1:0] KPG_K = 2'b00;
  localparam logic [1:0] KPG_P = 2'b01;
  localparam logic [1:0] KPG_G = 2'b10;

  function automatic logic [1:0] kpg_op(input logic [1:0] x, input logic [1:0] y);
    return (y == KPG_P) ? x : y;
  endfunction

  logic                   stall;
  logic [WIDTH-1:0]       a_q, bp_q, bp_d;
  logic                   c0_d;
  logic [S:0]             v_q, c0_q;
  logic [2*WIDTH-1:0]     init_kpg;
  logic [2*WIDTH-1:0]     stage_in [S];
  logic [2*WIDTH-1:0]     grp_d    [S];
  logic [2*WIDTH-1:0]     grp_q    [S];
  logic [WIDTH-1:0]       prop_q   [S];
  logic [WIDTH:0]         carry_d;
  logic [WIDTH-1:0]       sum_d, sum_q;
  logic                   cout_d, ovf_d, zero_d;
  logic                   cout_q, ovf_q, zero_q, out_valid_q;

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;

  always_comb begin
    bp_d = sub ? ~b : b;
    c0_d = sub | cin;
  end

  // The carry-in slot is folded into bit 0 so the network only needs log2(WIDTH) levels.
  always_comb begin
    init_kpg = '0;
    for (int i = 0; i < WIDTH; i++) begin
      init_kpg[2*i +: 2] = {a_q[i] & bp_q[i], a_q[i] ^ bp_q[i]};
    end
    init_kpg[1:0] = kpg_op(c0_q[0] ? KPG_G : KPG_K, init_kpg[1:0]);
  end

  always_comb begin
    logic [2*WIDTH-1:0] cur;
    logic [2*WIDTH-1:0] nxt;
    cur = '0;
    nxt = '0;
    stage_in[0] = init_kpg;
    for (int j = 1; j < S; j++) begin
      stage_in[j] = grp_q[j-1];
    end
    for (int s = 0; s < S; s++) begin
      cur = stage_in[s];
      for (int lv = s * LPS; (lv < (s + 1) * LPS) && (lv < L); lv++) begin
        nxt = cur;
        for (int i = (1 << lv); i < WIDTH; i++) begin
          nxt[2*i +: 2] = kpg_op(cur[2*(i - (1 << lv)) +: 2], cur[2*i +: 2]);
        end
        cur = nxt;
      end
      grp_d[s] = cur;
    end
  end

  // Prefix result at bit i-1 already includes the carry-in, so it is the carry into bit i.
  always_comb begin
    carry_d    = '0;
    carry_d[0] = c0_q[S];
    for (int i = 1; i <= WIDTH; i++) begin
      carry_d[i] = (grp_q[S-1][2*(i-1) +: 2] == KPG_G);
    end
    sum_d  = prop_q[S-1] ^ carry_d[WIDTH-1:0];
    cout_d = carry_d[WIDTH];
    ovf_d  = carry_d[WIDTH-1] ^ carry_d[WIDTH];
    zero_d = ~|sum_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q         <= '0;
      c0_q        <= '0;
      a_q         <= '0;
      bp_q        <= '0;
      for (int s = 0; s < S; s++) begin
        grp_q[s]  <= '0;
        prop_q[s] <= '0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (!stall) begin
      v_q         <= {v_q[S-1:0], in_valid};
      c0_q        <= {c0_q[S-1:0], c0_d};
      a_q         <= a;
      bp_q        <= bp_d;
      prop_q[0]   <= a_q ^ bp_q;
      for (int s = 1; s < S; s++) begin
        prop_q[s] <= prop_q[s-1];
      end
      for (int s = 0; s < S; s++) begin
        grp_q[s]  <= grp_d[s];
      end
      out_valid_q <= v_q[S];
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
